// File: rtl/rv32_ex_wb_stage_pkg.sv
// Shared RV32 types for the execute/writeback slice: register type, ALU op encoding,
// branch funct3 constants and the buffered writeback entry.
package rv32_ex_wb_stage_pkg;

    typedef logic [31:0] rv_register_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_EQ
    } rv_alu_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [4:0]   rd;
        rv_register_t data;
        logic         wb_en;
    } wb_entry_t;

    // ALU operation that feeds the zero flag for a given branch funct3.
    function automatic rv_alu_op_t br_alu_op(input logic [2:0] funct3);
        unique case (funct3)
            F3_BLT, F3_BGE:   br_alu_op = ALU_SLT;
            F3_BLTU, F3_BGEU: br_alu_op = ALU_SLTU;
            default:          br_alu_op = ALU_EQ;
        endcase
    endfunction

endpackage

// File: rtl/rv32_ex_wb_stage_br_cond.sv
// Branch resolution from funct3 and the ALU zero flag (ALU_EQ/SLT/SLTU yield 1 when the
// "positive" condition holds, so the zero flag marks the inverted sense).
module rv32_br_cond
    import rv32_ex_wb_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       z,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ, F3_BLT, F3_BLTU: taken = ~z;
            F3_BNE, F3_BGE, F3_BGEU: taken = z;
            default:                 taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_ex_wb_stage.sv
// Execute-to-writeback stage: two-entry skid buffer (main + skid), branch/jump redirect
// pulse and 64-bit retired-instruction counter.
module rv32_ex_wb_stage
    import rv32_ex_wb_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  rv_register_t alu_res,
    input  logic         alu_z,
    input  logic [4:0]   in_rd,
    input  logic         in_wb_en,
    input  logic         in_is_branch,
    input  logic         in_is_jump,
    input  logic [2:0]   in_br_funct3,
    input  rv_register_t in_pc,
    input  rv_register_t in_target,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   wb_rd,
    output rv_register_t wb_data,
    output logic         wb_en,
    output logic         redirect_valid,
    output rv_register_t redirect_pc,
    output logic [63:0]  instret
);

    wb_entry_t    r_main, w_main_d;
    wb_entry_t    r_skid, w_skid_d;
    logic         r_main_v, w_main_v_d;
    logic         r_skid_v, w_skid_v_d;
    logic         r_in_ready;
    logic         r_redirect_valid, w_redirect_valid_d;
    rv_register_t r_redirect_pc, w_redirect_pc_d;
    logic [63:0]  r_instret;

    logic         w_taken;
    logic         w_accept;
    logic         w_retire;
    wb_entry_t    w_new;

    rv32_br_cond u_br_cond (
        .funct3 (in_br_funct3),
        .z      (alu_z),
        .taken  (w_taken)
    );

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_retire = r_main_v & out_ready & ~flush;

    always_comb begin
        w_new.rd    = in_rd;
        w_new.data  = in_is_jump ? (in_pc + 32'd4) : alu_res;
        w_new.wb_en = in_wb_en & (in_rd != 5'd0) & ~in_is_branch;
    end

    // Skid can only be full while in_ready is low, so accept and skid drain never coincide.
    always_comb begin
        w_main_d   = r_main;
        w_skid_d   = r_skid;
        w_main_v_d = r_main_v;
        w_skid_v_d = r_skid_v;
        if (flush) begin
            w_main_v_d = 1'b0;
            w_skid_v_d = 1'b0;
        end else if (w_retire && r_skid_v) begin
            w_main_d   = r_skid;
            w_skid_v_d = 1'b0;
        end else if (w_accept && (!r_main_v || w_retire)) begin
            w_main_d   = w_new;
            w_main_v_d = 1'b1;
        end else if (w_accept) begin
            w_skid_d   = w_new;
            w_skid_v_d = 1'b1;
        end else if (w_retire) begin
            w_main_v_d = 1'b0;
        end
    end

    always_comb begin
        w_redirect_valid_d = w_accept & (in_is_jump | (in_is_branch & w_taken));
        w_redirect_pc_d    = w_redirect_valid_d ? in_target : r_redirect_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main           <= '0;
            r_skid           <= '0;
            r_main_v         <= 1'b0;
            r_skid_v         <= 1'b0;
            r_in_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_instret        <= '0;
        end else begin
            r_main           <= w_main_d;
            r_skid           <= w_skid_d;
            r_main_v         <= w_main_v_d;
            r_skid_v         <= w_skid_v_d;
            r_in_ready       <= ~w_skid_v_d;
            r_redirect_valid <= w_redirect_valid_d;
            r_redirect_pc    <= w_redirect_pc_d;
            if (w_retire) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_main_v;
    assign wb_rd          = r_main.rd;
    assign wb_data        = r_main.data;
    assign wb_en          = r_main.wb_en;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign instret        = r_instret;

endmodule

// File: tb/tb_rv32_ex_wb_stage.sv
// Scoreboard bench for rv32_ex_wb_stage: directed vectors carry hand-computed writeback and
// redirect expectations; a negedge monitor pushes on accept and pops on retire.
module tb_rv32_ex_wb_stage;
    import rv32_ex_wb_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    rv_register_t alu_res;
    logic         alu_z;
    logic [4:0]   in_rd;
    logic         in_wb_en;
    logic         in_is_branch;
    logic         in_is_jump;
    logic [2:0]   in_br_funct3;
    rv_register_t in_pc;
    rv_register_t in_target;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   wb_rd;
    rv_register_t wb_data;
    logic         wb_en;
    logic         redirect_valid;
    rv_register_t redirect_pc;
    logic [63:0]  instret;

    always #5 clk = ~clk;

    rv32_ex_wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_res        (alu_res),
        .alu_z          (alu_z),
        .in_rd          (in_rd),
        .in_wb_en       (in_wb_en),
        .in_is_branch   (in_is_branch),
        .in_is_jump     (in_is_jump),
        .in_br_funct3   (in_br_funct3),
        .in_pc          (in_pc),
        .in_target      (in_target),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_en          (wb_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instret        (instret)
    );

    typedef struct {
        rv_register_t res;
        logic         z;
        logic [4:0]   rd;
        logic         wben;
        logic         br;
        logic         jmp;
        logic [2:0]   f3;
        rv_register_t pc;
        rv_register_t tgt;
        logic [4:0]   e_rd;
        rv_register_t e_data;
        logic         e_wb;
        logic         e_redir;
        rv_register_t e_rpc;
    } vec_t;

    vec_t         cur;
    vec_t         sbq[$];
    int unsigned  nvec = 0;
    int unsigned  nerr = 0;
    logic [63:0]  exp_instret = '0;
    logic         exp_redir = 1'b0;
    rv_register_t exp_rpc = '0;
    logic [63:0]  saved_instret;

    function automatic vec_t mk(rv_register_t res, logic z, logic [4:0] rd, logic wben,
                                logic br, logic jmp, logic [2:0] f3, rv_register_t pc,
                                rv_register_t tgt, logic [4:0] e_rd, rv_register_t e_data,
                                logic e_wb, logic e_redir, rv_register_t e_rpc);
        vec_t v;
        v.res = res; v.z = z; v.rd = rd; v.wben = wben; v.br = br; v.jmp = jmp; v.f3 = f3;
        v.pc = pc; v.tgt = tgt; v.e_rd = e_rd; v.e_data = e_data; v.e_wb = e_wb;
        v.e_redir = e_redir; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        cur          = v;
        in_valid     = 1'b1;
        alu_res      = v.res;
        alu_z        = v.z;
        in_rd        = v.rd;
        in_wb_en     = v.wben;
        in_is_branch = v.br;
        in_is_jump   = v.jmp;
        in_br_funct3 = v.f3;
        in_pc        = v.pc;
        in_target    = v.tgt;
    endtask

    // Returns at posedge+1 after the accepting edge, with in_valid dropped.
    task automatic wait_acc();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic send(input vec_t v);
        drive(v);
        wait_acc();
    endtask

    // Monitor / scoreboard
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                exp_redir   = 1'b0;
                exp_instret = '0;
            end else begin
                chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, exp_redir});
                if (exp_redir) chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, exp_rpc});
                if (flush) begin
                    sbq.delete();
                    exp_redir = 1'b0;
                end else begin
                    if (out_valid && out_ready) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_retire", 64'd1, 64'd0);
                        end else begin
                            e = sbq.pop_front();
                            chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.e_rd});
                            chk("wb_data", {32'd0, wb_data}, {32'd0, e.e_data});
                            chk("wb_en", {63'd0, wb_en}, {63'd0, e.e_wb});
                        end
                        exp_instret = exp_instret + 64'd1;
                    end
                    exp_redir = in_valid && in_ready && cur.e_redir;
                    if (in_valid && in_ready) begin
                        sbq.push_back(cur);
                        if (cur.e_redir) exp_rpc = cur.e_rpc;
                    end
                end
            end
        end
    end

    initial begin
        vec_t v_beq, v_jal, v_add0, v_add, v_bne, v_bge, v_bltu, v_f010, v_f011, v_jalr, v_wboff;
        vec_t v_a, v_b, v_c, v_d, v_e, v_f, v_g, v_h, v_i;
        //          res           z     rd     wen   br    jmp   f3      pc
        //          tgt           e_rd  e_data        e_wb  redir rpc
        v_beq  = mk(32'd1,        1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 3'b000, 32'h40,
                    32'h100,      5'd5, 32'd1,        1'b0, 1'b1, 32'h100);
        v_jal  = mk(32'h1234,     1'b0, 5'd1,  1'b1, 1'b0, 1'b1, 3'b000, 32'hFFFFFFFC,
                    32'h200,      5'd1, 32'h0,        1'b1, 1'b1, 32'h200);
        v_add0 = mk(32'd5,        1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 3'b000, 32'h50,
                    32'h0,        5'd0, 32'd5,        1'b0, 1'b0, 32'h0);
        v_add  = mk(32'hDEADBEEF, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 3'b000, 32'h54,
                    32'h0,        5'd7, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        v_bne  = mk(32'd1,        1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 3'b001, 32'h58,
                    32'h300,      5'd0, 32'd1,        1'b0, 1'b0, 32'h0);
        v_bge  = mk(32'd0,        1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 3'b101, 32'h5C,
                    32'h400,      5'd0, 32'd0,        1'b0, 1'b1, 32'h400);
        v_bltu = mk(32'd1,        1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 3'b110, 32'h60,
                    32'h500,      5'd4, 32'd1,        1'b0, 1'b1, 32'h500);
        v_f010 = mk(32'd1,        1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 3'b010, 32'h64,
                    32'h600,      5'd0, 32'd1,        1'b0, 1'b0, 32'h0);
        v_f011 = mk(32'd0,        1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 3'b011, 32'h68,
                    32'h700,      5'd0, 32'd0,        1'b0, 1'b0, 32'h0);
        v_jalr = mk(32'h9999,     1'b0, 5'd31, 1'b1, 1'b0, 1'b1, 3'b000, 32'h1000,
                    32'h2468,     5'd31, 32'h1004,    1'b1, 1'b1, 32'h2468);
        v_wboff = mk(32'h55,      1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 3'b000, 32'h70,
                    32'h0,        5'd3, 32'h55,       1'b0, 1'b0, 32'h0);
        v_a = mk(32'hA, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000, 32'h80, 32'h0,
                 5'd10, 32'hA, 1'b1, 1'b0, 32'h0);
        v_b = mk(32'hB, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 3'b000, 32'h84, 32'h0,
                 5'd11, 32'hB, 1'b1, 1'b0, 32'h0);
        v_c = mk(32'hC, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 3'b000, 32'h88, 32'h0,
                 5'd12, 32'hC, 1'b1, 1'b0, 32'h0);
        v_d = mk(32'hD, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 3'b000, 32'h8C, 32'h0,
                 5'd13, 32'hD, 1'b1, 1'b0, 32'h0);
        v_e = mk(32'hE, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 3'b000, 32'h90, 32'h0,
                 5'd14, 32'hE, 1'b1, 1'b0, 32'h0);
        v_f = mk(32'hF, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 3'b000, 32'h94, 32'h0,
                 5'd15, 32'hF, 1'b1, 1'b0, 32'h0);
        v_g = mk(32'h16, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 3'b000, 32'h98, 32'h0,
                 5'd16, 32'h16, 1'b1, 1'b0, 32'h0);
        v_h = mk(32'h17, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 3'b000, 32'h9C, 32'h0,
                 5'd17, 32'h17, 1'b1, 1'b0, 32'h0);
        v_i = mk(32'h18, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0, 3'b000, 32'hA0, 32'h0,
                 5'd18, 32'h18, 1'b1, 1'b0, 32'h0);

        cur = v_add0;
        cur.e_redir = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; alu_res = '0; alu_z = 1'b0; in_rd = '0;
        in_wb_en = 1'b0; in_is_branch = 1'b0; in_is_jump = 1'b0; in_br_funct3 = '0;
        in_pc = '0; in_target = '0; flush = 1'b0; out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_instret", instret, 64'd0);
        chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("rst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with out_ready=1: accept and retire overlap with no bubble.
        out_ready = 1'b1;
        send(v_beq);
        send(v_jal);
        send(v_add0);
        send(v_add);
        send(v_bne);
        send(v_bge);
        send(v_bltu);
        send(v_f010);
        send(v_f011);
        send(v_jalr);
        send(v_wboff);
        chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("instret_stream", instret, 64'd11);
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Back-pressure: two held, third stalls until release.
        out_ready = 1'b0;
        send(v_a);
        send(v_b);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        drive(v_c);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_stalled", {63'd0, in_ready}, 64'd0);
        chk("bp_head_rd", {59'd0, wb_rd}, 64'd10);
        chk("bp_instret_held", instret, 64'd11);
        out_ready = 1'b1;
        wait_acc();
        repeat (4) @(posedge clk);
        #1;
        chk("instret_bp", instret, 64'd14);

        // Flush with both entries full; out_ready high during flush must not retire.
        out_ready = 1'b0;
        send(v_d);
        send(v_e);
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        saved_instret = instret;
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_instret", instret, saved_instret);
        send(v_f);
        repeat (2) @(posedge clk);
        #1;
        chk("instret_after_flush", instret, 64'd15);

        // Reset mid-stream with held entries.
        out_ready = 1'b0;
        send(v_g);
        send(v_h);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_instret", instret, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(v_i);
        repeat (2) @(posedge clk);
        #1;
        chk("instret_after_rst", instret, 64'd1);
        chk("exp_instret_model", instret, exp_instret);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rv32_ex_wb_stage.md
RV32_EX_WB_STAGE -- requirements
Module: rv32_ex_wb_stage

Interface
REQ-001 SHALL have exactly one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 SHALL have rst_n (input, 1): asynchronous, active-low reset.
REQ-003 in_valid  input 1: execute slot holds a valid instruction.
REQ-004 in_ready  output 1: stage can accept this cycle.
REQ-005 alu_res  input rv_register_t: ALU result for the slot.
REQ-006 alu_z  input 1: ALU zero flag for the slot.
REQ-007 in_rd  input 5: destination register index.
REQ-008 in_wb_en  input 1: instruction writes rd.
REQ-009 in_is_branch  input 1: conditional branch.
REQ-010 in_is_jump  input 1: JAL/JALR.
REQ-011 in_br_funct3  input 3: branch funct3.
REQ-012 in_pc  input rv_register_t: instruction PC.
REQ-013 in_target  input rv_register_t: precomputed branch/jump target.
REQ-014 flush  input 1: discard all held entries.
REQ-015 out_valid  output 1: writeback entry presented.
REQ-016 out_ready  input 1: writeback consumer accepts.
REQ-017 wb_rd  output 5: destination register.
REQ-018 wb_data  output rv_register_t: write data.
REQ-019 wb_en  output 1: register write enable.
REQ-020 redirect_valid  output 1: one-cycle fetch redirect pulse.
REQ-021 redirect_pc  output rv_register_t: redirect address.
REQ-022 instret  output 64: retired-instruction count.

Function
REQ-023 Input handshake: accept when in_valid && in_ready; output handshake: retire when out_valid && out_ready.
REQ-024 Two-entry skid buffer (main + skid); in_ready SHALL be a register output, equal to NOT skid_valid.
REQ-025 Capture on accept when main empty, or main retiring this cycle with skid empty; otherwise capture into skid.
REQ-026 On main retire with skid full: skid moves to main, skid empties, in_ready rises next cycle.
REQ-027 Latency: an accepted entry SHALL be presented on out_valid the next cycle when the buffer was empty.
REQ-028 Branch taken: branches use ALU_EQ (BEQ/BNE), ALU_SLT (BLT/BGE) or ALU_SLTU (BLTU/BGEU); taken = NOT alu_z when funct3[0]=0, alu_z when funct3[0]=1.
REQ-029 funct3 010/011 SHALL be treated as not taken.
REQ-030 wb_data SHALL be in_pc+4 (mod 2^32) for jumps, otherwise alu_res.
REQ-031 wb_en SHALL be 0 when rd=0, for branches, or when in_wb_en=0.
REQ-032 Accepting a taken branch or a jump SHALL assert redirect_valid for exactly the next cycle, with redirect_pc = in_target.
REQ-033 instret SHALL increment by 1 per output handshake and wrap from 2^64-1 to 0.
REQ-034 Flush SHALL clear both entries next cycle and set in_ready=1.
REQ-035 During a flush cycle: no capture, no retire, no instret increment, no redirect.
REQ-036 Simultaneous accept and retire with main full and skid empty SHALL replace main with no bubble.

Reset
REQ-037 During reset: out_valid=0, redirect_valid=0, in_ready=1, instret=0, wb_rd=0, wb_data=0, wb_en=0, redirect_pc=0.
REQ-038 Reset mid-operation SHALL drop held entries without retiring them.

Structure
REQ-039 rv_register_t, rv_alu_op_t, and branch funct3 constants SHALL live in the shared types package; no local redefinition.
REQ-040 The branch condition SHALL be a sub-module rv32_br_cond (funct3, z -> taken).

Verification
REQ-041 BEQ with alu_z=0 (ALU_EQ res=1), in_target=0x100 -> redirect_valid pulse next cycle, redirect_pc=0x100, wb_en=0.
REQ-042 JAL with in_pc=0xFFFFFFFC, rd=1 -> wb_data=0x00000000, wb_en=1, redirect_valid=1.
REQ-043 out_ready=0 with 3 back-to-back inputs -> 2 held, in_ready=0 after second; release -> retire in order, no loss.
REQ-044 flush with both entries full -> out_valid=0 next cycle, instret unchanged, in_ready=1.
REQ-045 ADD with rd=0, alu_res=5 -> out_valid=1, wb_en=0; instret increments by 1.
REQ-046 rst_n low mid-stream with held entries -> out_valid=0 immediately, instret=0.
